// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target register file.
package i2c_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdataAck
  } i2c_tgt_state_e;

  localparam int unsigned I2C_BYTE_BITS = 8;
  localparam logic        I2C_ACK       = 1'b0;
  localparam logic        I2C_NACK      = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA into the clk domain and derives SCL edges plus START/STOP events.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_b,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda
);

  // [0] and [1] are the synchroniser, [2] is the history flop. Reset to the idle-bus level.
  logic [2:0] scl_q, sda_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  end

  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  assign start_det = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop_det  = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
  assign sda       = sda_q[1];

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with a register file and auto-incrementing pointer; reports every written byte.
module i2c_target_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR = 7'h50,
  parameter int unsigned NUM_REGS   = 16
) (
  input  logic                        clk,
  input  logic                        rst_b,
  input  logic                        scl_i,
  input  logic                        sda_i,
  output logic                        sda_oe,
  output logic                        busy,
  output logic                        wr_valid,
  output logic [$clog2(NUM_REGS)-1:0] wr_addr,
  output logic [7:0]                  wr_data
);

  localparam int unsigned PtrW = $clog2(NUM_REGS);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync u_bus_sync (
    .clk      (clk),
    .rst_b    (rst_b),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det),
    .sda      (sda_s)
  );

  i2c_tgt_state_e  state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic            ptr_set_q, ptr_set_d;
  logic            sda_oe_q, sda_oe_d;
  logic            busy_q, busy_d;
  logic            wr_valid_q, wr_valid_d;
  logic [PtrW-1:0] wr_addr_q;
  logic [7:0]      wr_data_q;
  logic [7:0]      regs_q [NUM_REGS];
  logic            we;
  logic [7:0]      rd_byte;

  assign rd_byte = regs_q[ptr_q];

  // In ACK states cnt tracks the 9th bit: 0 before the drive fall, 1 driving, 2 after the rise.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    ptr_set_d  = ptr_set_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    we         = 1'b0;
    if (stop_det) begin
      state_d  = StIdle;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d   = StAddr;
      cnt_d     = 4'd0;
      sda_oe_d  = 1'b0;
      ptr_set_d = 1'b0;
    end else begin
      case (state_q)
        StAddr, StPtr, StWdata: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'(I2C_BYTE_BITS - 1)) begin
              cnt_d = 4'd0;
              if (state_q == StAddr) begin
                if (shift_d[7:1] == SLAVE_ADDR) begin
                  state_d = StAddrAck;
                  busy_d  = 1'b1;
                end else begin
                  state_d = StIdle;
                end
              end else if (state_q == StPtr) begin
                ptr_d     = shift_d[PtrW-1:0];
                ptr_set_d = 1'b1;
                state_d   = StPtrAck;
              end else begin
                we         = 1'b1;
                wr_valid_d = 1'b1;
                state_d    = StWdataAck;
              end
            end
          end
        end
        StAddrAck, StPtrAck, StWdataAck: begin
          if (scl_fall && cnt_q == 4'd0) begin
            sda_oe_d = 1'b1;
            cnt_d    = 4'd1;
          end else if (scl_rise && cnt_q == 4'd1) begin
            cnt_d = 4'd2;
          end else if (scl_fall && cnt_q == 4'd2) begin
            sda_oe_d = 1'b0;
            cnt_d    = 4'd0;
            if (state_q == StAddrAck) begin
              if (shift_q[0]) begin
                state_d  = StRdata;
                shift_d  = rd_byte;
                sda_oe_d = ~rd_byte[7];
              end else begin
                state_d = ptr_set_q ? StWdata : StPtr;
              end
            end else if (state_q == StPtrAck) begin
              state_d = StWdata;
            end else begin
              ptr_d   = ptr_q + 1'b1;
              state_d = StWdata;
            end
          end
        end
        StRdata: begin
          if (scl_rise && cnt_q < 4'(I2C_BYTE_BITS)) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'(I2C_BYTE_BITS)) begin
              sda_oe_d = 1'b0;
              cnt_d    = 4'd0;
              state_d  = StRdataAck;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        StRdataAck: begin
          if (scl_rise && cnt_q == 4'd0) begin
            if (sda_s == I2C_ACK) begin
              ptr_d = ptr_q + 1'b1;
              cnt_d = 4'd1;
            end else begin
              state_d = StIdle;
            end
          end else if (scl_fall && cnt_q == 4'd1) begin
            cnt_d    = 4'd0;
            state_d  = StRdata;
            shift_d  = rd_byte;
            sda_oe_d = ~rd_byte[7];
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      shift_q    <= 8'h00;
      ptr_q      <= '0;
      ptr_set_q  <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 8'h00;
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      ptr_set_q  <= ptr_set_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      if (we) begin
        regs_q[ptr_q] <= shift_d;
        wr_addr_q     <= ptr_q;
        wr_data_q     <= shift_d;
      end
    end
  end

  assign sda_oe   = sda_oe_q;
  assign busy     = busy_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench: bit-banged I2C master driving the target, checked against a byte-array register model.
module tb_i2c_target_regfile;

  localparam int unsigned NumRegs = 16;
  localparam int unsigned PtrW    = 4;
  localparam time         Q       = 80ns;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic scl = 1'b1;
  logic sda_m = 1'b1;
  logic sda_bus;
  logic sda_oe, busy, wr_valid;
  logic [PtrW-1:0] wr_addr;
  logic [7:0] wr_data;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_target_regfile #(
    .SLAVE_ADDR(7'h50),
    .NUM_REGS  (NumRegs)
  ) dut (
    .clk     (clk),
    .rst_b   (rst_b),
    .scl_i   (scl),
    .sda_i   (sda_bus),
    .sda_oe  (sda_oe),
    .busy    (busy),
    .wr_valid(wr_valid),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  always #5ns clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: register contents, pointer, and expected write reports.
  logic [7:0]  mem [NumRegs];
  int          ptr = 0;
  logic [7:0]  dbuf [16];
  logic [11:0] exp_q[$];
  logic [11:0] got_q[$];
  logic        oe_seen = 1'b0;
  logic        dbl_pulse = 1'b0;
  logic        wv_prev = 1'b0;

  always @(negedge clk) begin
    if (rst_b && wr_valid) got_q.push_back({wr_addr, wr_data});
    if (wr_valid && wv_prev) dbl_pulse = 1'b1;
    wv_prev = wr_valid;
    if (sda_oe) oe_seen = 1'b1;
  end

  task automatic bit_io(input logic b, output logic s);
    sda_m = b;
    #Q scl = 1'b1;
    #Q s = sda_bus;
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic bus_start();
    sda_m = 1'b1;
    #Q scl = 1'b1;
    #Q sda_m = 1'b0;
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0;
    #Q scl = 1'b1;
    #Q sda_m = 1'b1;
    #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_io(b[i], s);
    bit_io(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] r);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, s);
      r[i] = s;
    end
    bit_io(nack, s);
  endtask

  function automatic void model_write(input logic [7:0] p, input int n);
    ptr = int'(p) % NumRegs;
    for (int k = 0; k < n; k++) begin
      mem[ptr] = dbuf[k];
      exp_q.push_back({4'(ptr), dbuf[k]});
      ptr = (ptr + 1) % NumRegs;
    end
  endfunction

  // Write pointer p and n bytes from dbuf, then compare reported writes with the model.
  task automatic xfer_write(input logic [7:0] p, input int n, input string tag);
    logic ack;
    got_q.delete();
    exp_q.delete();
    dbl_pulse = 1'b0;
    bus_start();
    write_byte(8'hA0, ack);
    checks++;
    if (ack !== 1'b1) begin
      failures++;
      $display("FAIL %s addr_ack got=%b want=1", tag, ack);
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL %s busy_during got=%b want=1", tag, busy);
    end
    write_byte(p, ack);
    checks++;
    if (ack !== 1'b1) begin
      failures++;
      $display("FAIL %s ptr_ack got=%b want=1", tag, ack);
    end
    for (int k = 0; k < n; k++) begin
      write_byte(dbuf[k], ack);
      checks++;
      if (ack !== 1'b1) begin
        failures++;
        $display("FAIL %s data_ack[%0d] got=%b want=1", tag, k, ack);
      end
    end
    bus_stop();
    repeat (6) @(negedge clk);
    model_write(p, n);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s wr_count got=%0d want=%0d", tag, got_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL %s wr_event[%0d] got=%h want=%h", tag, k, got_q[k], exp_q[k]);
      end
    end
    checks++;
    if (dbl_pulse !== 1'b0) begin
      failures++;
      $display("FAIL %s wr_valid_width got=multi-cycle want=single", tag);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s busy_after_stop got=%b want=0", tag, busy);
    end
  endtask

  // Read n bytes, optionally setting the pointer first via a repeated START.
  task automatic xfer_read(input logic [7:0] p, input int n, input logic set_ptr,
                           input string tag);
    logic ack;
    logic [7:0] r;
    bus_start();
    if (set_ptr) begin
      write_byte(8'hA0, ack);
      write_byte(p, ack);
      ptr = int'(p) % NumRegs;
      bus_start();
    end
    write_byte(8'hA1, ack);
    checks++;
    if (ack !== 1'b1) begin
      failures++;
      $display("FAIL %s rd_addr_ack got=%b want=1", tag, ack);
    end
    for (int k = 0; k < n; k++) begin
      read_byte(k == n - 1, r);
      checks++;
      if (r !== mem[ptr]) begin
        failures++;
        $display("FAIL %s rd_byte[%0d] got=%h want=%h", tag, k, r, mem[ptr]);
      end
      if (k != n - 1) ptr = (ptr + 1) % NumRegs;
    end
    @(negedge clk);
    checks++;
    if (sda_oe !== 1'b0) begin
      failures++;
      $display("FAIL %s sda_released_after_nack got=%b want=0", tag, sda_oe);
    end
    bus_stop();
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({sda_oe, busy, wr_valid, wr_addr, wr_data} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b%b%b %h %h want=0", sda_oe, busy, wr_valid, wr_addr,
               wr_data);
    end
    rst_b = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({sda_oe, busy, wr_valid} !== 3'b000) begin
      failures++;
      $display("FAIL post_reset_idle got=%b%b%b want=000", sda_oe, busy, wr_valid);
    end
  endtask

  task automatic test_write_burst();
    dbuf[0] = 8'h11;
    dbuf[1] = 8'h22;
    xfer_write(8'h03, 2, "write_burst");
  endtask

  task automatic test_read_after_ptr();
    xfer_read(8'h03, 2, 1'b1, "read_after_ptr");
  endtask

  task automatic test_addr_mismatch();
    logic ack;
    got_q.delete();
    oe_seen = 1'b0;
    bus_start();
    write_byte(8'hA2, ack);
    checks++;
    if (ack !== 1'b0) begin
      failures++;
      $display("FAIL mismatch_ack got=%b want=0", ack);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL mismatch_busy got=%b want=0", busy);
    end
    write_byte(8'h03, ack);
    write_byte(8'h55, ack);
    bus_stop();
    repeat (6) @(negedge clk);
    checks++;
    if (oe_seen !== 1'b0) begin
      failures++;
      $display("FAIL mismatch_sda_oe got=asserted want=never");
    end
    checks++;
    if (got_q.size() != 0) begin
      failures++;
      $display("FAIL mismatch_wr_count got=%0d want=0", got_q.size());
    end
  endtask

  task automatic test_pointer_wrap();
    dbuf[0] = 8'hAA;
    dbuf[1] = 8'hBB;
    xfer_write(8'h0F, 2, "wrap_write");
    xfer_read(8'h0F, 2, 1'b1, "wrap_read");
  endtask

  task automatic test_stop_mid_byte();
    logic ack;
    logic s;
    logic [7:0] partial;
    partial = 8'hF0;
    got_q.delete();
    bus_start();
    write_byte(8'hA0, ack);
    write_byte(8'h07, ack);
    ptr = 7;
    for (int i = 7; i >= 4; i--) bit_io(partial[i], s);
    bus_stop();
    repeat (6) @(negedge clk);
    checks++;
    if (got_q.size() != 0) begin
      failures++;
      $display("FAIL stop_mid_wr_count got=%0d want=0", got_q.size());
    end
    checks++;
    if ({busy, sda_oe} !== 2'b00) begin
      failures++;
      $display("FAIL stop_mid_idle got=%b%b want=00", busy, sda_oe);
    end
    dbuf[0] = 8'h5A;
    xfer_write(8'h07, 1, "after_stop_write");
    xfer_read(8'h06, 3, 1'b1, "after_stop_read");
  endtask

  task automatic test_random();
    logic [7:0] p;
    int n;
    for (int it = 0; it < 5; it++) begin
      p = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) dbuf[k] = 8'($urandom);
      xfer_write(p, n, "rand_write");
      xfer_read(p, n, 1'b1, "rand_read");
    end
    // Continue reading from wherever the pointer was left.
    xfer_read(8'h00, 2, 1'b0, "rand_cont_read");
  endtask

  task automatic test_reset_mid_read();
    logic ack;
    int waited;
    dbuf[0] = 8'h3C;
    xfer_write(8'h05, 1, "pre_reset_write");
    bus_start();
    write_byte(8'hA0, ack);
    write_byte(8'h05, ack);
    bus_start();
    write_byte(8'hA1, ack);
    waited = 0;
    while (sda_oe !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (sda_oe !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_read_drive got=%b want=1", sda_oe);
    end
    @(negedge clk);
    #2ns rst_b = 1'b0;
    #1ns;
    checks++;
    if (sda_oe !== 1'b0) begin
      failures++;
      $display("FAIL reset_async_release got=%b want=0", sda_oe);
    end
    sda_m = 1'b1;
    #Q scl = 1'b1;
    #Q;
    @(negedge clk);
    rst_b = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < int'(NumRegs); i++) mem[i] = 8'h00;
    ptr = 0;
    xfer_read(8'h00, NumRegs, 1'b1, "post_reset_read");
  endtask

  initial begin
    for (int i = 0; i < int'(NumRegs); i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    test_reset();
    test_write_burst();
    test_read_after_ptr();
    test_addr_mismatch();
    test_pointer_wrap();
    test_stop_mid_byte();
    test_random();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
